// File: rtl/sdram_resp_model.sv
// sdram_resp_model: fixed-latency word-array responder for the ram_* request interface
module sdram_resp_model #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_ram,
    input  logic        rst,
    input  logic [3:0]  ram_wr_i,
    input  logic        ram_rd_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_write_data_i,
    output logic [31:0] ram_read_data_o,
    output logic        ram_accept_o,
    output logic        ram_ack_o,
    output logic        ram_error_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_err;
    logic [31:0]        r_dat [LATENCY];
    logic [3:0]         r_out;
    logic [31:0]        w_idx;
    logic [31:0]        w_rdat;
    logic               w_take;
    logic               w_err;
    assign ram_accept_o    = r_out < 4'(MAX_OUTSTANDING);
    assign w_take          = (ram_rd_i | (|ram_wr_i)) & ram_accept_o;
    assign w_idx           = (ram_addr_i - BASE_ADDR) >> 2;
    assign w_err           = (w_idx >= DEPTH_WORDS) || (ram_addr_i < BASE_ADDR) || (ram_rd_i && |ram_wr_i);
    assign w_rdat          = (w_err || !ram_rd_i) ? '0 : r_mem[w_idx[AW-1:0]];
    assign ram_ack_o       = r_vld[LATENCY-1];
    assign ram_error_o     = r_err[LATENCY-1];
    assign ram_read_data_o = r_dat[LATENCY-1];
    always_ff @(posedge clk_ram) begin
        if (w_take && !w_err && !rst)
            for (int b = 0; b < 4; b++)
                if (ram_wr_i[b]) r_mem[w_idx[AW-1:0]][8*b +: 8] <= ram_write_data_i[8*b +: 8];
    end
    // Idle stages carry zero data/error so the last stage can drive the outputs directly.
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            r_out <= '0;
            for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= w_take;
            r_err[0] <= w_take & w_err;
            r_dat[0] <= w_take ? w_rdat : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            r_out <= r_out + 4'(w_take) - 4'(ram_ack_o);
        end
    end
endmodule

// File: tb/tb_sdram_resp_model.sv
// tb_sdram_resp_model: directed and random requests checked against a queue-based reference model
module tb_sdram_resp_model;
    localparam int DEPTH = 1024;
    localparam logic [31:0] BASE = 32'h0;
    localparam int LAT = 2;
    localparam int MAXO = 2;
    logic        clk_ram = 0;
    logic        rst = 1;
    logic [3:0]  ram_wr_i = 0;
    logic        ram_rd_i = 0;
    logic [31:0] ram_addr_i = 0;
    logic [31:0] ram_write_data_i = 0;
    logic [31:0] ram_read_data_o;
    logic        ram_accept_o;
    logic        ram_ack_o;
    logic        ram_error_o;
    sdram_resp_model #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_ram(clk_ram), .rst(rst), .ram_wr_i(ram_wr_i), .ram_rd_i(ram_rd_i),
        .ram_addr_i(ram_addr_i), .ram_write_data_i(ram_write_data_i),
        .ram_read_data_o(ram_read_data_o), .ram_accept_o(ram_accept_o),
        .ram_ack_o(ram_ack_o), .ram_error_o(ram_error_o)
    );
    always #5 clk_ram = ~clk_ram;
    typedef struct { int due; bit err; logic [31:0] data; } exp_t;
    exp_t        q[$];
    logic [31:0] mem_m [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_data = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask
    function automatic void model_req(input bit rd, input logic [3:0] wr, input logic [31:0] a,
                                      input logic [31:0] d, output bit e, output logic [31:0] rdat);
        logic [31:0] off = a - BASE;
        int idx = int'(off / 4);
        logic [31:0] w;
        e = !(a >= BASE && off / 4 < DEPTH) || (rd && wr != 0);
        rdat = 0;
        if (!e) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            if (rd) rdat = w;
            else begin
                for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = d[8*b +: 8];
                mem_m[idx] = w;
            end
        end
    endfunction
    task automatic check_cycle(output bit acc_exp);
        bit ack_exp = q.size() > 0 && q[0].due == cyc;
        acc_exp = q.size() < MAXO;
        chk("accept", 32'(ram_accept_o), 32'(acc_exp));
        chk("ack", 32'(ram_ack_o), 32'(ack_exp));
        chk("error", 32'(ram_error_o), ack_exp ? 32'(q[0].err) : 32'h0);
        chk("rdata", ram_read_data_o, ack_exp ? q[0].data : 32'h0);
        if (ack_exp) begin
            last_data = ram_read_data_o;
            void'(q.pop_front());
        end
    endtask
    task automatic step(input bit rd, input logic [3:0] wr, input logic [31:0] a,
                        input logic [31:0] d, output bit taken);
        bit acc, e;
        logic [31:0] rdat;
        ram_rd_i = rd; ram_wr_i = wr; ram_addr_i = a; ram_write_data_i = d;
        check_cycle(acc);
        taken = acc && (rd || wr != 0);
        if (taken) begin
            model_req(rd, wr, a, d, e, rdat);
            q.push_back('{cyc + LAT, e, rdat});
        end
        @(posedge clk_ram); #1; cyc++;
        ram_rd_i = 0; ram_wr_i = 0;
    endtask
    task automatic req(input bit rd, input logic [3:0] wr, input logic [31:0] a, input logic [31:0] d);
        bit taken = 0;
        int tries = 0;
        while (!taken && tries < 10) begin
            step(rd, wr, a, d, taken);
            tries++;
        end
        if (!taken) chk("accept_timeout", 32'h0, 32'h1);
    endtask
    task automatic idle();
        bit t;
        step(0, 4'h0, 32'h0, 32'h0, t);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            idle();
            n++;
        end
        chk("drain", 32'(q.size()), 32'h0);
    endtask
    task automatic reset_cycle();
        bit acc;
        rst = 1;
        check_cycle(acc);
        q.delete();
        @(posedge clk_ram); #1; cyc++;
        rst = 0;
    endtask
    initial begin
        bit t;
        repeat (3) @(posedge clk_ram);
        #1;
        rst = 0;
        for (int i = 0; i < 16; i++) req(0, 4'hF, 32'(i * 4), $urandom);
        drain();
        // write then read back-to-back
        req(0, 4'hF, 32'h10, 32'hDEADBEEF);
        req(1, 4'h0, 32'h10, 32'h0);
        drain();
        chk("wr_rd_data", last_data, 32'hDEADBEEF);
        // byte enables
        req(0, 4'hF, 32'h20, 32'h11223344);
        req(0, 4'b0101, 32'h20, 32'hAABBCCDD);
        req(1, 4'h0, 32'h20, 32'h0);
        drain();
        chk("byte_en", last_data, 32'h11BB33DD);
        // backpressure: four back-to-back reads
        for (int i = 0; i < 4; i++) req(1, 4'h0, 32'(i * 4), 32'h0);
        drain();
        // errors
        req(1, 4'h0, 32'h1000, 32'h0);
        req(0, 4'hF, 32'h8, 32'h55667788);
        req(1, 4'h1, 32'h8, 32'h000000FF);
        req(1, 4'h0, 32'h8, 32'h0);
        drain();
        chk("err_no_effect", last_data, 32'h55667788);
        // reset mid-flight: in-flight read dropped, memory kept
        req(1, 4'h0, 32'h10, 32'h0);
        reset_cycle();
        idle();
        idle();
        req(1, 4'h0, 32'h10, 32'h0);
        drain();
        chk("mem_after_rst", last_data, 32'hDEADBEEF);
        // address low bits ignored
        req(0, 4'hF, 32'h33, 32'hCAFEF00D);
        req(1, 4'h0, 32'h30, 32'h0);
        drain();
        chk("low_bits", last_data, 32'hCAFEF00D);
        // random traffic
        for (int n = 0; n < 300; n++) begin
            int kind = $urandom_range(0, 9);
            logic [31:0] a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (kind == 0) idle();
            else if (kind == 1) req(1, 4'h0, 32'h1000 + 32'($urandom_range(0, 4095)), 32'h0);
            else if (kind == 2) req(1, 4'($urandom_range(1, 15)), a, $urandom);
            else if (kind < 6) req(1, 4'h0, a, 32'h0);
            else req(0, 4'($urandom_range(1, 15)), a, $urandom);
        end
        drain();
        step(0, 4'h0, 32'h0, 32'h0, t);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_resp_model.md
Name: sdram_resp_model

Overview:
- Responder for the 32-bit ram_* request interface driven by the gated-clock bridge; it is the memory end of that protocol.
- Accepts read/write requests under accept backpressure and returns exactly one ack per accepted request, with fixed latency, read data and an error flag.
- Backed by an internal word-addressed array; used as an on-chip RAM target and as the SDRAM stand-in for system simulation.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 2, cycles from the accept cycle to the ack cycle (1..8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unacked requests (1..LATENCY).

Ports:
- clk_ram  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ram_wr_i  in  4  byte write enables; [0]=bits 7:0.
- ram_rd_i  in  1  read request.
- ram_addr_i  in  32  byte address; bits [1:0] ignored.
- ram_write_data_i  in  32  write data.
- ram_read_data_o  out  32  read data, valid with ack.
- ram_accept_o  out  1  request accepted this cycle if a request is present.
- ram_ack_o  out  1  one-cycle completion pulse.
- ram_error_o  out  1  error status, valid with ack.

Behaviour:
- Reset values: ram_accept_o=1, ram_ack_o=0, ram_error_o=0, ram_read_data_o=0. Outstanding count is 0 and all pipeline slots are invalid.
- Request present when ram_rd_i=1 or ram_wr_i!=0.
- Accept rule: ram_accept_o = (outstanding < MAX_OUTSTANDING). It is driven from registered state only and is not a function of the inputs.
- A request is taken in any cycle where it is present and ram_accept_o=1. The requester holds all request inputs stable until that cycle.
- Word index = (ram_addr_i - BASE_ADDR) >> 2, computed modulo 2^32.
- The request is in range when the index < DEPTH_WORDS and BASE_ADDR <= ram_addr_i.
- Error conditions:
  - out of range, or
  - ram_rd_i=1 and ram_wr_i!=0 in the same request.
- Errored requests have no memory effect and return data 0 with ram_error_o=1.
- Writes commit in the accept cycle. Only the enabled bytes are updated; the rest keep their value. Write acks return data 0.
- Reads sample the array in the accept cycle, after any write committed in an earlier cycle, so a read always sees every previously accepted write.
- Latency: the request accepted in cycle T is acked in cycle T+LATENCY. The ack is a single-cycle pulse with data and error for that request only.
- Throughput is one accept per cycle when allowed. Acks are returned in acceptance order.
- Pipeline: LATENCY-stage shift register of {valid, error, data}. Stage 0 loads on accept; ack = valid at the last stage.
- Outstanding counter:
  - +1 on accept, -1 on ack, unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING, never goes below 0.
- Same-cycle ack and accept with outstanding == MAX_OUTSTANDING: ram_accept_o was 0 that cycle, so no accept happens. Accept reopens the next cycle.
- While ram_ack_o=0: ram_read_data_o=0 and ram_error_o=0.
- Reset mid-operation: all in-flight requests are dropped and no acks are issued for them. Writes already committed remain in the array. ram_accept_o=1 in the cycle after rst deasserts.
- Array contents are not reset. Simulation initialises them to 0.

Test Plan:
1. Write then read: write addr 0x10, wr=4'hF, data 0xDEADBEEF, accepted at T -> ack at T+2 with data 0, err 0. Read addr 0x10 accepted at T+1 -> ack at T+3 with data 0xDEADBEEF.
2. Byte enables: word 0x20 = 0x11223344; write wr=4'b0101, data 0xAABBCCDD -> a later read returns 0x11BB33DD.
3. Backpressure: back-to-back reads with MAX_OUTSTANDING=2, LATENCY=2:
   - accepts at T and T+1; ram_accept_o=0 at T+2;
   - acks at T+2 and T+3; accept resumes at T+3;
   - exactly one ack per accepted request, in order.
4. Errors:
   - read at BASE_ADDR+4*DEPTH_WORDS (0x1000) -> ack with err=1, data 0;
   - rd=1 with wr=4'h1 at addr 0x8 -> ack with err=1, and word 0x8 is unchanged on a later read.
5. Reset mid-flight: accept a read at T, assert rst at T+1 -> no ack at T+2. Outputs stay at reset values; ram_accept_o=1 after release.
6. Address low bits: write addr 0x33 -> a read at 0x30 returns the written data.
